// File: rtl/gshare_pht.sv
// Gshare pattern history table: 2-bit saturating counters indexed by PC ^ GHR,
// with a registered prediction, a speculative GHR shift, GHR repair on mispredict, and a same-edge update bypass.
module gshare_pht #(
  parameter int INDEX_WIDTH = 8,
  parameter int HIST_WIDTH  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   lookup_en_i,
  input  logic [31:0]            pc_i,
  output logic                   pred_valid_o,
  output logic                   pred_taken_o,
  output logic [1:0]             pred_state_o,
  output logic [INDEX_WIDTH-1:0] pred_index_o,
  output logic [HIST_WIDTH-1:0]  pred_hist_o,
  input  logic                   update_en_i,
  input  logic [INDEX_WIDTH-1:0] update_index_i,
  input  logic                   update_taken_i,
  input  logic                   update_mispredict_i,
  input  logic [HIST_WIDTH-1:0]  update_hist_i,
  output logic [HIST_WIDTH-1:0]  ghr_o
);

  localparam int         ENTRIES  = 2 ** INDEX_WIDTH;
  localparam logic [1:0] CTR_INIT = 2'b01;  // weakly not-taken

  logic [1:0]             table_q [ENTRIES];
  logic [HIST_WIDTH-1:0]  ghr_q, ghr_next;
  logic [INDEX_WIDTH-1:0] lookup_index;
  logic [1:0]             upd_cur, upd_next, lookup_state;
  logic                   repair;

  logic                   pred_valid_q;
  logic [1:0]             pred_state_q;
  logic [INDEX_WIDTH-1:0] pred_index_q;
  logic [HIST_WIDTH-1:0]  pred_hist_q;

  // NOTE: every variable gets a default at the top of the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    repair       = update_en_i && update_mispredict_i;
    lookup_index = pc_i[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(ghr_q);
    upd_cur      = table_q[update_index_i];
    upd_next     = upd_cur;
    if (update_taken_i) begin
      if (upd_cur != 2'b11) upd_next = upd_cur + 2'd1;
    end else begin
      if (upd_cur != 2'b00) upd_next = upd_cur - 2'd1;
    end
    // A lookup colliding with this edge's update sees the post-update counter.
    lookup_state = (update_en_i && (update_index_i == lookup_index)) ? upd_next
                                                                    : table_q[lookup_index];
    // Truncating {hist, bit} to HIST_WIDTH is a left shift that also covers HIST_WIDTH = 1.
    ghr_next = ghr_q;
    if (lookup_en_i) ghr_next = HIST_WIDTH'({ghr_q, lookup_state[1]});
    if (repair)      ghr_next = HIST_WIDTH'({update_hist_i, update_taken_i});
  end

  // NOTE: the table is reset to a known counter value, so it is built from flops rather than an SRAM macro.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= CTR_INIT;
    end else if (en_i && update_en_i) begin
      table_q[update_index_i] <= upd_next;
    end
  end

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ghr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_state_q <= 2'b00;
      pred_index_q <= '0;
      pred_hist_q  <= '0;
    end else if (en_i) begin
      ghr_q        <= ghr_next;
      pred_valid_q <= lookup_en_i && !repair;
      if (lookup_en_i) begin
        pred_state_q <= lookup_state;
        pred_index_q <= lookup_index;
        pred_hist_q  <= ghr_q;
      end
    end
  end

  assign pred_valid_o = pred_valid_q;
  assign pred_state_o = pred_state_q;
  assign pred_taken_o = pred_state_q[1];
  assign pred_index_o = pred_index_q;
  assign pred_hist_o  = pred_hist_q;
  assign ghr_o        = ghr_q;

endmodule

// File: tb/tb_gshare_pht.sv
// Self-checking bench for gshare_pht: directed scenarios plus randomized traffic
// compared against an integer-arithmetic reference model of the predictor.
module tb_gshare_pht;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i, lookup_en_i, update_en_i, update_taken_i, update_mispredict_i;
  logic [31:0] pc_i;
  logic [7:0]  update_index_i, update_hist_i;
  logic        pred_valid_o, pred_taken_o;
  logic [1:0]  pred_state_o;
  logic [7:0]  pred_index_o, pred_hist_o, ghr_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_ctr [256];
  int m_ghr, m_pv, m_ps, m_pi, m_ph;

  gshare_pht #(.INDEX_WIDTH(8), .HIST_WIDTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .lookup_en_i(lookup_en_i), .pc_i(pc_i),
    .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o), .pred_state_o(pred_state_o),
    .pred_index_o(pred_index_o), .pred_hist_o(pred_hist_o),
    .update_en_i(update_en_i), .update_index_i(update_index_i), .update_taken_i(update_taken_i),
    .update_mispredict_i(update_mispredict_i), .update_hist_i(update_hist_i), .ghr_o(ghr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void mdl_reset();
    for (int i = 0; i < 256; i++) m_ctr[i] = 1;
    m_ghr = 0; m_pv = 0; m_ps = 0; m_pi = 0; m_ph = 0;
  endfunction

  function automatic int mdl_index(input logic [31:0] pc);
    return ((pc >> 2) % 256) ^ m_ghr;
  endfunction

  // One clock edge of the predictor, stated as the behavioural rules.
  function automatic void mdl_edge(input bit en, input bit lk, input logic [31:0] pc,
                                   input bit ue, input int ui, input bit ut, input bit um, input int uh);
    int idx, nc, st;
    if (!en) return;
    idx = mdl_index(pc);
    nc  = ut ? ((m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3) : ((m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0);
    st  = (ue && ui == idx) ? nc : m_ctr[idx];
    if (lk) begin
      m_pv = 1; m_pi = idx; m_ph = m_ghr; m_ps = st;
      m_ghr = (m_ghr * 2 + st / 2) % 256;
    end else begin
      m_pv = 0;
    end
    if (ue) begin
      m_ctr[ui] = nc;
      if (um) begin
        m_ghr = (uh * 2 + (ut ? 1 : 0)) % 256;
        m_pv  = 0;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 32'(pred_valid_o), 32'(m_pv));
    check({tag, ".state"}, 32'(pred_state_o), 32'(m_ps));
    check({tag, ".taken"}, 32'(pred_taken_o), 32'(m_ps / 2));
    check({tag, ".index"}, 32'(pred_index_o), 32'(m_pi));
    check({tag, ".hist"},  32'(pred_hist_o),  32'(m_ph));
    check({tag, ".ghr"},   32'(ghr_o),        32'(m_ghr));
  endtask

  task automatic cyc(input string tag, input bit en, input bit lk, input logic [31:0] pc,
                     input bit ue, input int ui, input bit ut, input bit um, input int uh);
    en_i = en; lookup_en_i = lk; pc_i = pc;
    update_en_i = ue; update_index_i = ui[7:0]; update_taken_i = ut;
    update_mispredict_i = um; update_hist_i = uh[7:0];
    mdl_edge(en, lk, pc, ue, ui, ut, um, uh);
    @(posedge clk_i); #1;
    check_all(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".valid"}, 32'(pred_valid_o), 0);
    check({tag, ".taken"}, 32'(pred_taken_o), 0);
    check({tag, ".state"}, 32'(pred_state_o), 0);
    check({tag, ".index"}, 32'(pred_index_o), 0);
    check({tag, ".hist"},  32'(pred_hist_o),  0);
    check({tag, ".ghr"},   32'(ghr_o),        0);
  endtask

  initial begin
    logic [1:0] sat_exp [8];
    logic [7:0] s_idx, s_hist, s_ghr;
    logic [1:0] s_state;
    logic       s_valid;
    int         idx;
    sat_exp = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};

    rst_i = 1'b1; en_i = 0; lookup_en_i = 0; pc_i = '0; update_en_i = 0;
    update_index_i = '0; update_taken_i = 0; update_mispredict_i = 0; update_hist_i = '0;
    mdl_reset();
    repeat (2) @(posedge clk_i);
    #3 rst_i = 1'b0;
    #1 check_reset_outputs("por");

    // First lookup after reset
    cyc("lk0", 1, 1, 32'h0, 0, 0, 0, 0, 0);
    check("lk0.state_const", 32'(pred_state_o), 1);
    check("lk0.index_const", 32'(pred_index_o), 0);

    // Saturation at index 0x05, each step confirmed by a lookup
    for (int i = 0; i < 8; i++) begin
      cyc("sat.upd", 1, 0, 32'h0, 1, 5, (i < 4), 0, 0);
      cyc("sat.lk", 1, 1, 32'((5 ^ m_ghr) << 2), 0, 0, 0, 0, 0);
      check("sat.value", 32'(pred_state_o), 32'(sat_exp[i]));
    end

    // Mid-cycle async reset with an update pending
    en_i = 1; update_en_i = 1; update_index_i = 8'h05; update_taken_i = 1; lookup_en_i = 1;
    #2 rst_i = 1'b1;
    mdl_reset();
    #1 check_reset_outputs("midrst");
    update_en_i = 0; lookup_en_i = 0;
    @(posedge clk_i); #3 rst_i = 1'b0;
    @(posedge clk_i); #1 check_all("postrst");

    // Speculative GHR
    cyc("spec.upd", 1, 0, 32'h0, 1, 8'h10, 1, 0, 0);
    cyc("spec.upd", 1, 0, 32'h0, 1, 8'h10, 1, 0, 0);
    cyc("spec.lk1", 1, 1, 32'h40, 0, 0, 0, 0, 0);
    check("spec.idx1", 32'(pred_index_o), 32'h10);
    check("spec.taken1", 32'(pred_taken_o), 1);
    check("spec.ghr1", 32'(ghr_o), 32'h01);
    cyc("spec.lk2", 1, 1, 32'h40, 0, 0, 0, 0, 0);
    check("spec.idx2", 32'(pred_index_o), 32'h11);
    check("spec.hist2", 32'(pred_hist_o), 32'h01);

    // Repair plus flush with a same-edge lookup
    cyc("repair", 1, 1, 32'h0, 1, 8'h33, 1, 1, 8'h5A);
    check("repair.ghr", 32'(ghr_o), 32'hB5);
    check("repair.valid", 32'(pred_valid_o), 0);

    // Same-edge bypass at index 0x22
    cyc("bypass", 1, 1, 32'((8'h22 ^ m_ghr) << 2), 1, 8'h22, 1, 0, 0);
    check("bypass.index", 32'(pred_index_o), 32'h22);
    check("bypass.state", 32'(pred_state_o), 2);

    // Stall: en_i low freezes everything
    s_valid = pred_valid_o; s_state = pred_state_o; s_idx = pred_index_o;
    s_hist = pred_hist_o; s_ghr = ghr_o;
    for (int i = 0; i < 3; i++) begin
      cyc("stall", 0, 1, 32'h1234, 1, 8'h22, 1, 1, 8'hFF);
      check("stall.valid", 32'(pred_valid_o), 32'(s_valid));
      check("stall.state", 32'(pred_state_o), 32'(s_state));
      check("stall.index", 32'(pred_index_o), 32'(s_idx));
      check("stall.hist", 32'(pred_hist_o), 32'(s_hist));
      check("stall.ghr", 32'(ghr_o), 32'(s_ghr));
    end
    cyc("stall.after", 1, 1, 32'((8'h22 ^ m_ghr) << 2), 0, 0, 0, 0, 0);
    check("stall.ctr", 32'(pred_state_o), 2);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      bit en, lk, ue, ut, um;
      pc  = $urandom & 32'h0000_03FC;
      en  = ($urandom_range(0, 9) != 0);
      lk  = ($urandom_range(0, 3) != 0);
      ue  = ($urandom_range(0, 1) != 0);
      ut  = ($urandom_range(0, 1) != 0);
      um  = ($urandom_range(0, 4) == 0);
      idx = ($urandom_range(0, 3) == 0) ? mdl_index(pc) : int'($urandom_range(0, 255));
      cyc("rand", en, lk, pc, ue, idx, ut, um, int'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
